chan_scan_seq: RTL and testbench

Channel scan sequencer that drives the 2-bit channel select and enable of the one-hot channel decoder directly downstream. On a start pulse it latches a channel mask and a dwell time, then steps round-robin through the enabled channels. Each channel is held for the dwell time, and a one-cycle break-before-make gap separates consecutive channels. It runs one sweep (single-shot) or repeats until stopped (continuous).

---
 rtl/chan_scan_seq_pkg.sv | 13 +
 rtl/chan_scan_seq_next_ch_pick.sv | 38 +++
 rtl/chan_scan_seq.sv | 142 ++++++++++++++
 tb/tb_chan_scan_seq.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/chan_scan_seq_pkg.sv
// Shared definitions for the channel scan sequencer: state encodings and
// the channel-select width used by the downstream one-hot decoder.
package chan_scan_seq_pkg;

    localparam int CH_SEL_W = 2;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DWELL = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    typedef logic [CH_SEL_W-1:0] ch_idx_t;

endpackage

// File: rtl/chan_scan_seq_next_ch_pick.sv
// Combinational channel picker: next set mask bit above the current index
// (wrapping to the lowest set bit), plus the lowest set bit on its own.
module chan_scan_seq_next_ch_pick
    import chan_scan_seq_pkg::*;
#(
    parameter int NUM_CH = 4
) (
    input  logic [NUM_CH-1:0] mask,
    input  ch_idx_t           cur,
    output ch_idx_t           nxt,
    output logic              wrapped,
    output ch_idx_t           lowest
);

    ch_idx_t lowest_s;
    ch_idx_t higher_s;
    logic    low_found_s;
    logic    high_found_s;

    // Priority scans from bit 0 upward; the first hit wins in each scan.
    always_comb begin
        lowest_s     = {CH_SEL_W{1'b0}};
        higher_s     = {CH_SEL_W{1'b0}};
        low_found_s  = 1'b0;
        high_found_s = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            lowest_s     = (mask[i] && !low_found_s) ? CH_SEL_W'(i) : lowest_s;
            low_found_s  = low_found_s | mask[i];
            higher_s     = (mask[i] && (i > int'(cur)) && !high_found_s) ? CH_SEL_W'(i) : higher_s;
            high_found_s = high_found_s | (mask[i] && (i > int'(cur)));
        end
    end

    assign wrapped = ~high_found_s;
    assign nxt     = high_found_s ? higher_s : lowest_s;
    assign lowest  = lowest_s;

endmodule

// File: rtl/chan_scan_seq.sv
// Channel scan sequencer: latches mask/dwell/mode on start and steps the
// decoder select round-robin with a one-cycle break-before-make gap.
module chan_scan_seq
    import chan_scan_seq_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               cont,
    input  logic [NUM_CH-1:0]  ch_mask,
    input  logic [DWELL_W-1:0] dwell,
    output logic [1:0]         sel,
    output logic               sel_en,
    output logic               busy,
    output logic               done,
    output logic               err
);

    logic [1:0]         state_r;
    logic [DWELL_W-1:0] cnt_r;
    logic [DWELL_W-1:0] dwell_m1_r;
    logic [NUM_CH-1:0]  mask_r;
    logic               cont_r;
    ch_idx_t            sel_r;
    logic               sel_en_r;
    logic               busy_r;
    logic               done_r;
    logic               err_r;

    logic [NUM_CH-1:0]  pick_mask_s;
    logic [DWELL_W-1:0] dwell_m1_s;
    ch_idx_t            nxt_s;
    ch_idx_t            lowest_s;
    logic               wrapped_s;

    // A dwell of 0 behaves as 1, so the reload value saturates at zero.
    function automatic logic [DWELL_W-1:0] reload_of(input logic [DWELL_W-1:0] d);
        return (d == {DWELL_W{1'b0}}) ? {DWELL_W{1'b0}} : (d - DWELL_W'(1));
    endfunction

    // In IDLE the picker looks at the live mask so start can pick the first channel.
    always_comb begin
        pick_mask_s = (state_r == ST_IDLE) ? ch_mask : mask_r;
        dwell_m1_s  = reload_of(dwell);
    end

    chan_scan_seq_next_ch_pick #(
        .NUM_CH (NUM_CH)
    ) u_pick (
        .mask    (pick_mask_s),
        .cur     (sel_r),
        .nxt     (nxt_s),
        .wrapped (wrapped_s),
        .lowest  (lowest_s)
    );

    // Scan FSM, dwell counter, latched configuration and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            cnt_r      <= {DWELL_W{1'b0}};
            dwell_m1_r <= {DWELL_W{1'b0}};
            mask_r     <= {NUM_CH{1'b0}};
            cont_r     <= 1'b0;
            sel_r      <= {CH_SEL_W{1'b0}};
            sel_en_r   <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            done_r <= 1'b0;
            err_r  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start && !stop) begin
                        if (ch_mask != {NUM_CH{1'b0}}) begin
                            mask_r     <= ch_mask;
                            dwell_m1_r <= dwell_m1_s;
                            cont_r     <= cont;
                            cnt_r      <= dwell_m1_s;
                            sel_r      <= lowest_s;
                            sel_en_r   <= 1'b1;
                            busy_r     <= 1'b1;
                            state_r    <= ST_DWELL;
                        end else begin
                            err_r <= 1'b1;
                        end
                    end
                end
                ST_DWELL: begin
                    if (stop) begin
                        state_r  <= ST_IDLE;
                        sel_r    <= {CH_SEL_W{1'b0}};
                        sel_en_r <= 1'b0;
                        busy_r   <= 1'b0;
                    end else if (cnt_r != {DWELL_W{1'b0}}) begin
                        cnt_r <= cnt_r - DWELL_W'(1);
                    end else if (!wrapped_s || cont_r) begin
                        state_r  <= ST_GAP;
                        sel_en_r <= 1'b0;
                    end else begin
                        state_r  <= ST_IDLE;
                        sel_r    <= {CH_SEL_W{1'b0}};
                        sel_en_r <= 1'b0;
                        busy_r   <= 1'b0;
                        done_r   <= 1'b1;
                    end
                end
                ST_GAP: begin
                    if (stop) begin
                        state_r  <= ST_IDLE;
                        sel_r    <= {CH_SEL_W{1'b0}};
                        sel_en_r <= 1'b0;
                        busy_r   <= 1'b0;
                    end else begin
                        state_r  <= ST_DWELL;
                        sel_r    <= nxt_s;
                        cnt_r    <= dwell_m1_r;
                        sel_en_r <= 1'b1;
                    end
                end
                default: begin
                    state_r  <= ST_IDLE;
                    sel_r    <= {CH_SEL_W{1'b0}};
                    sel_en_r <= 1'b0;
                    busy_r   <= 1'b0;
                end
            endcase
        end
    end

    assign sel    = sel_r;
    assign sel_en = sel_en_r;
    assign busy   = busy_r;
    assign done   = done_r;
    assign err    = err_r;

endmodule

// File: tb/tb_chan_scan_seq.sv
// Directed bench for chan_scan_seq: per-cycle vector table plus hand-written
// continuous-mode, stop and mid-scan reset sequences.
module tb_chan_scan_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       stop;
    logic       cont;
    logic [3:0] ch_mask;
    logic [7:0] dwell;
    logic [1:0] sel;
    logic       sel_en;
    logic       busy;
    logic       done;
    logic       err;

    int n_chk  = 0;
    int n_pass = 0;

    // Expected outputs packed as {sel[1:0], sel_en, busy, done, err}.
    typedef struct {
        logic       start;
        logic       stop;
        logic       cont;
        logic [3:0] mask;
        logic [7:0] dwell;
        logic [5:0] exp;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    chan_scan_seq #(
        .NUM_CH  (4),
        .DWELL_W (8)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .stop    (stop),
        .cont    (cont),
        .ch_mask (ch_mask),
        .dwell   (dwell),
        .sel     (sel),
        .sel_en  (sel_en),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    function automatic logic [5:0] outs();
        return {sel, sel_en, busy, done, err};
    endfunction

    task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b required %b ({sel,sel_en,busy,done,err})", name, act, exp);
    endtask

    // Drive inputs, take one rising edge, settle just after it.
    task automatic cyc(input logic st, input logic sp, input logic ct,
                       input logic [3:0] m, input logic [7:0] d);
        start   = st;
        stop    = sp;
        cont    = ct;
        ch_mask = m;
        dwell   = d;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic st, input logic sp, input logic ct,
                       input logic [3:0] m, input logic [7:0] d, input logic [5:0] e);
        vec_t v;
        v.start = st; v.stop = sp; v.cont = ct; v.mask = m; v.dwell = d; v.exp = e;
        vecs.push_back(v);
    endtask

    initial begin
        // Single-shot mask 1011 dwell 3; mask/dwell wiggle mid-scan must be ignored.
        add(1'b1, 1'b0, 1'b0, 4'b1011, 8'd3, 6'b00_1100);
        add(1'b0, 1'b0, 1'b0, 4'b1011, 8'd3, 6'b00_1100);
        add(1'b0, 1'b0, 1'b1, 4'b0001, 8'd9, 6'b00_1100);
        add(1'b0, 1'b0, 1'b0, 4'b1011, 8'd3, 6'b00_0100);
        add(1'b0, 1'b0, 1'b0, 4'b1011, 8'd3, 6'b01_1100);
        add(1'b0, 1'b0, 1'b0, 4'b1011, 8'd3, 6'b01_1100);
        add(1'b0, 1'b0, 1'b0, 4'b1011, 8'd3, 6'b01_1100);
        add(1'b0, 1'b0, 1'b0, 4'b1011, 8'd3, 6'b01_0100);
        add(1'b0, 1'b0, 1'b0, 4'b1011, 8'd3, 6'b11_1100);
        add(1'b0, 1'b0, 1'b0, 4'b1011, 8'd3, 6'b11_1100);
        add(1'b0, 1'b0, 1'b0, 4'b1011, 8'd3, 6'b11_1100);
        add(1'b0, 1'b0, 1'b0, 4'b1011, 8'd3, 6'b00_0010);
        add(1'b0, 1'b0, 1'b0, 4'b1011, 8'd3, 6'b00_0000);
        // dwell 0 acts as 1.
        add(1'b1, 1'b0, 1'b0, 4'b0100, 8'd0, 6'b10_1100);
        add(1'b0, 1'b0, 1'b0, 4'b0100, 8'd0, 6'b00_0010);
        add(1'b0, 1'b0, 1'b0, 4'b0100, 8'd0, 6'b00_0000);
        // Empty mask raises err for one cycle only.
        add(1'b1, 1'b0, 1'b0, 4'b0000, 8'd2, 6'b00_0001);
        add(1'b0, 1'b0, 1'b0, 4'b0000, 8'd2, 6'b00_0000);
        // start and stop together in IDLE: stop wins, no err either.
        add(1'b1, 1'b1, 1'b0, 4'b1111, 8'd2, 6'b00_0000);
        add(1'b1, 1'b1, 1'b0, 4'b0000, 8'd2, 6'b00_0000);
        // Single-bit continuous mask still gets a gap between dwells.
        add(1'b1, 1'b0, 1'b1, 4'b0010, 8'd1, 6'b01_1100);
        add(1'b0, 1'b0, 1'b0, 4'b0010, 8'd1, 6'b01_0100);
        add(1'b0, 1'b0, 1'b0, 4'b0010, 8'd1, 6'b01_1100);
        add(1'b0, 1'b1, 1'b0, 4'b0010, 8'd1, 6'b00_0000);

        rst = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 4'b0000, 8'd0);
        cyc(1'b0, 1'b0, 1'b0, 4'b0000, 8'd0);
        check("reset", outs(), 6'b00_0000);
        rst = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 4'b0000, 8'd0);
        check("post_reset_idle", outs(), 6'b00_0000);

        foreach (vecs[i]) begin
            cyc(vecs[i].start, vecs[i].stop, vecs[i].cont, vecs[i].mask, vecs[i].dwell);
            check($sformatf("vec%0d", i), outs(), vecs[i].exp);
        end

        // Continuous mask 1001 dwell 2, a start while busy, then stop mid-dwell on ch 3.
        begin
            logic [5:0] cseq [0:9];
            cseq[0] = 6'b00_1100; cseq[1] = 6'b00_1100; cseq[2] = 6'b00_0100;
            cseq[3] = 6'b11_1100; cseq[4] = 6'b11_1100; cseq[5] = 6'b11_0100;
            cseq[6] = 6'b00_1100; cseq[7] = 6'b00_1100; cseq[8] = 6'b00_0100;
            cseq[9] = 6'b11_1100;
            for (int i = 0; i < 10; i++) begin
                cyc((i == 0 || i == 1) ? 1'b1 : 1'b0, 1'b0, 1'b1,
                    (i == 1) ? 4'b1111 : 4'b1001, 8'd2);
                check($sformatf("cont%0d", i), outs(), cseq[i]);
            end
            cyc(1'b0, 1'b1, 1'b1, 4'b1001, 8'd2);
            check("cont_stop", outs(), 6'b00_0000);
            cyc(1'b0, 1'b0, 1'b1, 4'b1001, 8'd2);
            check("cont_stop_no_done", outs(), 6'b00_0000);
        end

        // Mid-scan config change is ignored; reset clears everything, no done.
        cyc(1'b1, 1'b0, 1'b0, 4'b1011, 8'd3);
        check("rst_seq0", outs(), 6'b00_1100);
        cyc(1'b0, 1'b0, 1'b0, 4'b0001, 8'd1);
        check("rst_seq1", outs(), 6'b00_1100);
        cyc(1'b0, 1'b0, 1'b0, 4'b0001, 8'd1);
        check("rst_seq2", outs(), 6'b00_1100);
        cyc(1'b0, 1'b0, 1'b0, 4'b0001, 8'd1);
        check("rst_seq_gap", outs(), 6'b00_0100);
        cyc(1'b0, 1'b0, 1'b0, 4'b0001, 8'd1);
        check("rst_seq_ch1", outs(), 6'b01_1100);
        rst = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 4'b0001, 8'd1);
        check("rst_mid_scan", outs(), 6'b00_0000);
        rst = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 4'b0001, 8'd1);
        check("rst_no_done", outs(), 6'b00_0000);
        cyc(1'b1, 1'b0, 1'b0, 4'b0010, 8'd1);
        check("fresh_start", outs(), 6'b01_1100);
        cyc(1'b0, 1'b0, 1'b0, 4'b0010, 8'd1);
        check("fresh_done", outs(), 6'b00_0010);
        cyc(1'b0, 1'b0, 1'b0, 4'b0010, 8'd1);
        check("fresh_idle", outs(), 6'b00_0000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
